// File: rtl/uart_pkg.sv
// Shared UART package: arbiter state encoding and clog2-derived width helpers
// used by the TX/RX/APB blocks.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for single-entry cases.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int UART_NREQ   = 4;
  localparam int UART_DATA_W = 8;
  localparam int UART_ID_W   = idx_w(UART_NREQ);

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin picker: first set bit of valid_i searching upward from ptr_i
// with wrap-around.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = UART_NREQ,
  parameter int W = UART_ID_W
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N;
      if (valid_i[W'(cand)]) begin
        idx_o   = W'(cand);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter that lets NREQ byte streams share one
// UART transmitter through a single-entry output buffer.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_last,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       tx_valid,
  output logic [DATA_WIDTH-1:0]      tx_data,
  input  logic                       tx_ready,
  output logic [idx_w(NREQ)-1:0]     grant_id,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int ID_W  = idx_w(NREQ);
  localparam int CNT_W = idx_w(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      idle_q, idle_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] req_bytes [NREQ];
  logic [ID_W-1:0]       pick_idx;
  logic [ID_W-1:0]       next_ptr;
  logic                  pick_found;
  logic                  g_valid;
  logic                  g_last;
  logic                  slot_open;
  logic                  accept;

  rr_pick #(
    .N (NREQ),
    .W (ID_W)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = (state_q == ST_XFER) && slot_open && (grant_q == ID_W'(gi));
    end
  endgenerate

  // The buffer can take a new byte when empty or draining this cycle.
  assign slot_open = !tx_valid_q || tx_ready;
  assign g_valid   = req_valid[grant_q];
  assign g_last    = req_last[grant_q];
  assign accept    = (state_q == ST_XFER) && slot_open && g_valid;
  assign next_ptr  = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_d     = idle_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;

    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = req_bytes[grant_q];
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          idle_d  = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          idle_d = '0;
          if (g_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!g_valid) begin
          // A silent owner loses the grant; its buffered byte still drains.
          if (idle_q == CNT_LAST) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
            idle_d   = '0;
            err_d    = 1'b1;
          end else begin
            idle_d = idle_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      idle_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_q     <= idle_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q == ST_XFER);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized traffic, all
// checked against a packet/queue-level reference model.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy, err_timeout;

  uart_tx_arb #(
    .NREQ       (N),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-requester sources: {last, byte} entries, head is presented.
  bit [8:0]     src_q [N][$];
  logic [N-1:0] en, acc, obs_ready;

  // Reference model: owner, pointer, silence count, one-deep output slot.
  bit         m_busy, m_err;
  int         m_grant, m_ptr, m_idle;
  logic [7:0] m_buf[$];

  logic [7:0] out_q[$];
  int         out_cyc[$], grant_log[$], grant_cyc[$], err_cyc[$];

  int  n, leak, acc_cyc, phase, thr, len;
  bit  done1;
  bit  [8:0] tmp;
  logic [7:0] exp35 [4] = '{8'h11, 8'h12, 8'h13, 8'h21};
  logic [7:0] exp36 [3] = '{8'h55, 8'h66, 8'h77};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[2'(j)]) return j;
    end
    return 0;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (src_q[2'(i)].size() > 0 && en[2'(i)]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_grant = 0; m_ptr = 0; m_idle = 0;
    m_buf.delete();
  endtask

  task automatic clear_all();
    out_q.delete(); out_cyc.delete(); grant_log.delete();
    grant_cyc.delete(); err_cyc.delete();
    for (int i = 0; i < N; i++) src_q[2'(i)].delete();
  endtask

  // One clock: drive sources, check mid-cycle, advance model, cross the edge.
  task automatic cycle();
    logic [N-1:0]    v, l;
    logic [N*DW-1:0] d;
    bit [8:0]        head;
    bit              exp_rdy, accept_m, last_m;
    logic [7:0]      d_m;
    logic [1:0]      gs;
    int              g;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[2'(i)].size() > 0) begin
        head = src_q[2'(i)][0];
        v[2'(i)] = en[2'(i)];
        l[2'(i)] = head[8];
        d = d | (32'(head[7:0]) << (i * DW));
      end
    end
    req_valid = v; req_last = l; req_data = d;
    #1;
    exp_rdy = m_busy && (m_buf.size() == 0 || tx_ready);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant", 32'(grant_id), 32'(m_grant));
    chk("err", 32'(err_timeout), 32'(m_err));
    chk("txv", 32'(tx_valid), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) chk("txd", 32'(tx_data), 32'(m_buf[0]));
    chk("ready", 32'(req_ready), exp_rdy ? (32'd1 << m_grant) : 32'd0);
    $display("cyc=%0d rst=%0b v=%b rdy=%b txv=%0b txd=%h txr=%0b gnt=%0d busy=%0b err=%0b",
             cyc, rst, req_valid, req_ready, tx_valid, tx_data, tx_ready, grant_id, busy, err_timeout);
    obs_ready = req_ready;
    acc = req_valid & req_ready;
    if (tx_valid && tx_ready) begin out_q.push_back(tx_data); out_cyc.push_back(cyc); end
    if (err_timeout) err_cyc.push_back(cyc);

    g = m_grant; gs = 2'(g);
    accept_m = exp_rdy && req_valid[gs];
    last_m   = req_last[gs];
    d_m      = 8'(req_data >> (g * DW));
    if (rst) begin
      model_reset();
    end else begin
      if (m_buf.size() > 0 && tx_ready) void'(m_buf.pop_front());
      if (accept_m) m_buf.push_back(d_m);
      m_err = 0;
      if (!m_busy) begin
        if (req_valid != '0) begin
          m_grant = pick(req_valid, m_ptr);
          m_busy = 1; m_idle = 0;
          grant_log.push_back(m_grant); grant_cyc.push_back(cyc);
        end
      end else if (accept_m) begin
        m_idle = 0;
        if (last_m) begin m_busy = 0; m_ptr = (g + 1) % N; end
      end else if (!req_valid[gs]) begin
        m_idle++;
        if (m_idle == TO) begin m_busy = 0; m_err = 1; m_ptr = (g + 1) % N; m_idle = 0; end
      end
    end
    for (int i = 0; i < N; i++)
      if (acc[2'(i)]) void'(src_q[2'(i)].pop_front());
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int k = 0;
    while ((pending() || tx_valid || m_busy) && k < max) begin cycle(); k++; end
    chk(tag, 32'(k < max), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = '0; acc = '0; tx_ready = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single requester, two-byte packet.
    clear_all();
    src_q[0].push_back(9'h041); src_q[0].push_back(9'h142);
    en = 4'b0001; tx_ready = 1'b1;
    drain("r33_drain", 50);
    chk("r33_cnt", 32'(out_q.size()), 32'd2);
    chk("r33_b0", 32'(out_q[0]), 32'h41);
    chk("r33_b1", 32'(out_q[1]), 32'h42);
    chk("r33_gap", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
    chk("r33_busy", 32'(busy), 32'd0);

    // Everyone valid with single-byte packets: strict rotation with bubble.
    do_reset(); clear_all();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) src_q[2'(i)].push_back(9'h100 | 9'(i * 16 + k));
    en = 4'b1111; tx_ready = 1'b1;
    drain("r34_drain", 100);
    for (int k = 0; k < 5; k++) chk($sformatf("r34_g%0d", k), 32'(grant_log[k]), 32'(k % 4));
    for (int k = 1; k < 5; k++) chk($sformatf("r34_gap%0d", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd2);

    // Grant held across requester 1's packet.
    do_reset(); clear_all();
    src_q[1].push_back(9'h011); src_q[1].push_back(9'h012); src_q[1].push_back(9'h113);
    src_q[2].push_back(9'h121);
    en = 4'b0110; tx_ready = 1'b1; leak = 0; done1 = 0; n = 0;
    while ((pending() || tx_valid || m_busy) && n < 60) begin
      cycle(); n++;
      if (!done1 && obs_ready[2]) leak++;
      if (acc[1] && req_last[1]) done1 = 1;
    end
    chk("r35_leak", 32'(leak), 32'd0);
    chk("r35_done", 32'(done1), 32'd1);
    for (int k = 0; k < 4; k++) chk($sformatf("r35_b%0d", k), 32'(out_q[k]), 32'(exp35[k]));

    // Transmitter stalls with a byte buffered.
    do_reset(); clear_all();
    src_q[0].push_back(9'h055); src_q[0].push_back(9'h066); src_q[0].push_back(9'h177);
    en = 4'b0001; tx_ready = 1'b0; n = 0;
    while (!tx_valid && n < 10) begin cycle(); n++; end
    chk("r36_fill", 32'(tx_valid), 32'd1);
    repeat (10) begin
      cycle();
      chk("r36_data", 32'(tx_data), 32'h55);
      chk("r36_hold", 32'(req_ready), 32'd0);
    end
    chk("r36_none", 32'(out_q.size()), 32'd0);
    tx_ready = 1'b1;
    drain("r36_drain", 50);
    for (int k = 0; k < 3; k++) chk($sformatf("r36_b%0d", k), 32'(out_q[k]), 32'(exp36[k]));

    // Requester 3 goes silent mid-packet.
    do_reset(); clear_all();
    src_q[3].push_back(9'h0A1); src_q[3].push_back(9'h0A2); src_q[3].push_back(9'h1A3);
    src_q[0].push_back(9'h1B0);
    en = 4'b1000; tx_ready = 1'b1; acc = '0; n = 0;
    while (!acc[3] && n < 10) begin cycle(); n++; end
    acc_cyc = cyc - 1;
    en = 4'b0001;
    repeat (20) cycle();
    chk("r37_pulses", 32'(err_cyc.size()), 32'd1);
    chk("r37_delay", 32'(err_cyc[0] - acc_cyc), 32'd17);
    chk("r37_first", 32'(grant_log[0]), 32'd3);
    chk("r37_next", 32'(grant_log[1]), 32'd0);
    en = 4'b1001;
    drain("r37_drain", 100);

    // Reset with a byte buffered.
    do_reset(); clear_all();
    src_q[2].push_back(9'h033); src_q[2].push_back(9'h134);
    en = 4'b0100; tx_ready = 1'b0; n = 0;
    while (!tx_valid && n < 10) begin cycle(); n++; end
    chk("r38_fill", 32'(tx_valid), 32'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("r38_txv", 32'(tx_valid), 32'd0);
    chk("r38_grant", 32'(grant_id), 32'd0);
    chk("r38_busy", 32'(busy), 32'd0);
    tx_ready = 1'b1;
    drain("r38_drain", 50);

    // Randomized traffic: dense, sparse (timeouts) and mixed phases.
    do_reset(); clear_all();
    for (int c = 0; c < 3000; c++) begin
      phase = (c / 250) % 3;
      thr = (phase == 0) ? 14 : (phase == 1) ? 1 : 8;
      for (int i = 0; i < N; i++) begin
        while (src_q[2'(i)].size() < 2) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) src_q[2'(i)].push_back({b == len - 1, 8'($urandom)});
        end
        en[2'(i)] = ($urandom_range(0, 15) < thr);
        if (!en[2'(i)] && $urandom_range(0, 1) == 1) begin
          tmp = src_q[2'(i)][0];
          tmp[7:0] = 8'($urandom);
          src_q[2'(i)][0] = tmp;
        end
      end
      tx_ready = (phase == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; en = 4'b1111; tx_ready = 1'b1;
    drain("rand_drain", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
